// File: rtl/fcp6_pkg.sv
// Shared FCP6 command types: sequencer state encoding and the packed command word.
// No logic; widths here fix the FIFO entry size.
package fcp6_pkg;

  localparam int HDR_WIDTH   = 8;
  localparam int DATA_WIDTH  = 8;
  localparam int HDR_DIR_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic [HDR_WIDTH-1:0]  hdr;
    logic [DATA_WIDTH-1:0] dat;
  } cmd_t;

  localparam int CMD_WIDTH = HDR_WIDTH + DATA_WIDTH;

endpackage

// File: rtl/fcp6_cmd_fifo.sv
// Circular command FIFO; count updates on the edge after push/pop, head is read combinationally.
// A push while full is dropped even if a pop happens in the same cycle.
module fcp6_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fcp6_cmd_sequencer.sv
// Queues host commands and launches them one at a time to the FCP6 master; m_start 2 cycles after accept.
// req_ready drops only when the FIFO is full; responses and timeout pulses have no backpressure.
module fcp6_cmd_sequencer
  import fcp6_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [HDR_WIDTH-1:0]   req_header,
  input  logic [DATA_WIDTH-1:0]  req_data,
  output logic                   m_start,
  output logic [HDR_WIDTH-1:0]   m_header,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   m_busy,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  // Abort on the cycle whose increment would bring the counter to TIMEOUT-1,
  // so the pulse lands exactly TIMEOUT cycles after m_start.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 2);

  state_t          state;
  cmd_t            push_cmd;
  cmd_t            head_cmd;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_pop;
  logic [TW-1:0]   to_cnt;

  assign push_cmd.hdr = req_header;
  assign push_cmd.dat = req_data;
  assign fifo_pop     = (state == ST_LAUNCH);
  assign req_ready    = !fifo_full;
  assign idle         = (state == ST_IDLE) && fifo_empty;
  // Read data is taken live in the RESP cycle, so this path is combinational.
  assign rsp_data     = (rsp_valid && !rsp_write) ? m_rdata : '0;

  fcp6_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid),
    .push_dat (push_cmd),
    .pop      (fifo_pop),
    .head_dat (head_cmd),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Header/data are captured on entry to LAUNCH so they are valid alongside m_start;
  // the FIFO entry itself is retired during the LAUNCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      m_start     <= 1'b0;
      m_header    <= '0;
      m_data      <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      m_start     <= 1'b0;
      rsp_valid   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state    <= ST_LAUNCH;
            m_start  <= 1'b1;
            m_header <= head_cmd.hdr;
            m_data   <= head_cmd.dat;
          end
        end
        ST_LAUNCH: begin
          to_cnt <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (m_busy) begin
            state <= ST_WAIT_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
              err_timeout <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (!m_busy) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_write <= m_header[HDR_DIR_BIT];
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcp6_cmd_sequencer.sv
// Bench for fcp6_cmd_sequencer: directed scenarios then random traffic, checked every cycle
// against a queue-based command model and a behavioural FCP6 master.
module tb_fcp6_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic                   clk        = 1'b0;
  logic                   rst        = 1'b1;
  logic                   req_valid  = 1'b0;
  logic                   req_ready;
  logic [7:0]             req_header = 8'h00;
  logic [7:0]             req_data   = 8'h00;
  logic                   m_start;
  logic [7:0]             m_header;
  logic [7:0]             m_data;
  logic                   m_busy     = 1'b0;
  logic [7:0]             m_rdata    = 8'h00;
  logic                   rsp_valid;
  logic                   rsp_write;
  logic [7:0]             rsp_data;
  logic                   err_timeout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   idle;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fcp6_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_header(req_header), .req_data(req_data),
    .m_start(m_start), .m_header(m_header), .m_data(m_data), .m_busy(m_busy), .m_rdata(m_rdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .err_timeout(err_timeout), .fifo_count(fifo_count), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stimulus-side knobs (written only by the main block)
  bit         cfg_rand  = 1'b0;
  int         cfg_delay = 1;
  int         cfg_len   = 1;
  logic [7:0] cfg_rdata = 8'h00;
  int         never_at  = -1;

  // Model / master state (written only by the monitor block)
  int         cyc = 0;
  logic [15:0] model_q[$];
  int         m_phase = 0;
  int         m_cnt = 0;
  int         cur_len = 1;
  logic [7:0] m_val = 8'h00;
  logic [7:0] cur_hdr = 8'h00;
  int         exp_err_cyc = 0;
  bit         exp_rsp = 1'b0;
  logic       exp_wr = 1'b0;
  logic [7:0] exp_dat = 8'h00;
  bit         acc_flag = 1'b0;
  logic       prev_start = 1'b0;
  int         start_cnt = 0, rsp_cnt = 0, err_cnt = 0;
  int         last_err_cyc = 0, to_start_cyc = 0;
  logic       last_rsp_write = 1'b0;
  logic [7:0] last_rsp_data = 8'h00;

  // Master drives at +1, everything is checked at +2 after each rising edge.
  always @(posedge clk) begin
    logic [15:0] head;
    bit          exp_err;
    bit          go_never;
    int          delay;
    cyc++;
    #1;
    case (m_phase)
      1: begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 1'b1; m_cnt = cur_len; m_phase = 2; end
      end
      2: begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 1'b0; m_rdata = ~m_val; m_phase = 3; end
      end
      3: begin
        m_rdata = m_val;
        exp_rsp = 1'b1;
        exp_wr  = cur_hdr[0];
        exp_dat = cur_hdr[0] ? 8'h00 : m_val;
      end
      default: ;
    endcase
    #1;
    exp_err = (m_phase == 4) && (cyc == exp_err_cyc);
    chk("fifo_count", fifo_count, model_q.size());
    chk("req_ready", req_ready, model_q.size() != DEPTH);
    chk("rsp_valid", rsp_valid, exp_rsp);
    chk("err_timeout", err_timeout, exp_err);
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp_write = rsp_write;
      last_rsp_data  = rsp_data;
      if (exp_rsp) begin
        chk("rsp_write", rsp_write, exp_wr);
        chk("rsp_data", rsp_data, exp_dat);
      end
    end
    if (exp_rsp) begin exp_rsp = 1'b0; m_phase = 0; end
    if (err_timeout) begin err_cnt++; last_err_cyc = cyc; end
    if (exp_err) m_phase = 0;
    acc_flag = req_valid && !rst && (model_q.size() != DEPTH);
    if (m_start && !rst) begin
      chk("start_width", prev_start, 0);
      chk("start_outstanding", m_phase, 0);
      chk("start_queued", model_q.size() != 0, 1);
      if (model_q.size() != 0) begin
        head = model_q.pop_front();
        chk("m_header", m_header, head[15:8]);
        chk("m_data", m_data, head[7:0]);
        cur_hdr = head[15:8];
      end
      if (cfg_rand) begin
        delay    = $urandom_range(1, 4);
        cur_len  = $urandom_range(1, 5);
        m_val    = 8'($urandom);
        go_never = ($urandom_range(0, 9) == 0);
      end else begin
        delay    = cfg_delay;
        cur_len  = cfg_len;
        m_val    = cfg_rdata;
        go_never = 1'b0;
      end
      if (go_never || start_cnt == never_at) begin
        m_phase      = 4;
        exp_err_cyc  = cyc + TIMEOUT;
        to_start_cyc = cyc;
      end else begin
        m_phase = 1;
        m_cnt   = delay;
      end
      start_cnt++;
    end
    prev_start = m_start;
    if (acc_flag) model_q.push_back({req_header, req_data});
    if (rst) begin
      model_q.delete();
      m_phase    = 0;
      m_busy     = 1'b0;
      exp_rsp    = 1'b0;
      acc_flag   = 1'b0;
      prev_start = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] h, input logic [7:0] d);
    int n = 0;
    req_valid  = 1'b1;
    req_header = h;
    req_data   = d;
    do begin @(posedge clk); n++; end while (!acc_flag && n < 500);
    chk("push_accept", acc_flag, 1);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (!(idle === 1'b1 && m_phase == 0) && n < bound) begin tick(); n++; end
    chk({tag, "_drain"}, n < bound, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, s0, e0, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_m_header", m_header, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 1'b0;
    tick();

    // Single write, busy held 20 cycles
    cfg_delay = 1; cfg_len = 20; cfg_rdata = 8'h3C;
    r0 = rsp_cnt;
    push(8'h05, 8'h10);
    chk("wr_no_start_c1", m_start, 0);
    chk("wr_count_c1", fifo_count, 1);
    chk("wr_idle_c1", idle, 0);
    tick();
    chk("wr_start_c2", m_start, 1);
    chk("wr_m_header", m_header, 8'h05);
    chk("wr_m_data", m_data, 8'h10);
    tick();
    chk("wr_start_one_cycle", m_start, 0);
    wait_idle("wr", 200);
    chk("wr_rsp_cnt", rsp_cnt - r0, 1);
    chk("wr_rsp_write", last_rsp_write, 1);
    chk("wr_rsp_data", last_rsp_data, 8'h00);
    chk("wr_hdr_held", m_header, 8'h05);

    // Single read returning 0x58
    cfg_len = 3; cfg_rdata = 8'h58;
    r0 = rsp_cnt;
    push(8'h04, 8'hA5);
    wait_idle("rd", 200);
    chk("rd_rsp_cnt", rsp_cnt - r0, 1);
    chk("rd_rsp_write", last_rsp_write, 0);
    chk("rd_rsp_data", last_rsp_data, 8'h58);

    // Back-pressure: first command busy long, FIFO fills, then a push races the next pop
    cfg_len = 30; cfg_rdata = 8'hC3;
    r0 = rsp_cnt; s0 = start_cnt;
    push(8'h11, 8'h01);
    push(8'h20, 8'h02);
    push(8'h33, 8'h03);
    push(8'h40, 8'h04);
    push(8'h55, 8'h05);
    chk("bp_count_full", fifo_count, DEPTH);
    chk("bp_ready_low", req_ready, 0);
    req_valid = 1'b1; req_header = 8'h66; req_data = 8'h06;
    n = 0;
    while (m_start !== 1'b1 && n < 200) begin tick(); n++; end
    chk("bp_second_launch", n < 200, 1);
    chk("fp_ready_at_pop", req_ready, 0);
    chk("fp_count_at_pop", fifo_count, DEPTH);
    tick();
    chk("fp_count_after_pop", fifo_count, DEPTH - 1);
    chk("fp_ready_after_pop", req_ready, 1);
    tick();
    chk("fp_count_refill", fifo_count, DEPTH);
    req_valid = 1'b0;
    wait_idle("bp", 2000);
    chk("bp_rsp_cnt", rsp_cnt - r0, 6);
    chk("bp_start_cnt", start_cnt - s0, 6);

    // Timeout on a read, then the queued write still goes out
    cfg_len = 3; cfg_rdata = 8'h9E;
    r0 = rsp_cnt; s0 = start_cnt; e0 = err_cnt;
    never_at = start_cnt;
    push(8'h36, 8'h77);
    push(8'h81, 8'h99);
    wait_idle("to", 400);
    chk("to_err_cnt", err_cnt - e0, 1);
    chk("to_err_latency", last_err_cyc - to_start_cyc, TIMEOUT);
    chk("to_rsp_cnt", rsp_cnt - r0, 1);
    chk("to_start_cnt", start_cnt - s0, 2);
    chk("to_next_write", last_rsp_write, 1);

    // Reset while waiting for busy to fall with two commands queued
    cfg_len = 40;
    push(8'h0A, 8'h01);
    push(8'h0B, 8'h02);
    push(8'h0C, 8'h03);
    repeat (3) tick();
    chk("mr_count_before", fifo_count, 2);
    r0 = rsp_cnt; s0 = start_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_count", fifo_count, 0);
    chk("mr_idle", idle, 1);
    chk("mr_m_start", m_start, 0);
    chk("mr_m_header", m_header, 0);
    repeat (20) tick();
    chk("mr_no_start", start_cnt - s0, 0);
    chk("mr_no_rsp", rsp_cnt - r0, 0);
    chk("mr_idle_after", idle, 1);

    // Random traffic with random master timing
    cfg_rand = 1'b1;
    r0 = rsp_cnt; e0 = err_cnt;
    for (int i = 0; i < 30; i++) begin
      push(8'($urandom), 8'($urandom));
      n = $urandom_range(0, 3);
      repeat (n) tick();
    end
    wait_idle("rand", 5000);
    chk("rand_completions", (rsp_cnt - r0) + (err_cnt - e0), 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fcp6_cmd_sequencer.md
# fcp6_cmd_sequencer

Command front-end for the FCP6 master. Accepts header/data transaction requests from the host side into a small FIFO and issues them one at a time to the master's `start`/`header_in`/`data_in` inputs. Tracks the master's `busy` to detect completion, then returns one completion record per transaction, carrying read data for reads. Sits directly upstream of the FCP6 master inside `top`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: max cycles from `m_start` to `m_busy` rising before the command is aborted.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  FIFO can accept; `req_valid && req_ready` pushes.
- `req_header`  in  8  FCP6 header; bit 0 = 1 write, 0 read; bits [7:1] passed through unmodified.
- `req_data`  in  8  write byte; don't-care for reads but still stored.
- `m_start`  out  1  one-cycle launch pulse to master.
- `m_header`  out  8  header to master.
- `m_data`  out  8  data to master.
- `m_busy`  in  1  master transaction in progress.
- `m_rdata`  in  8  master's first received read byte.
- `rsp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `rsp_write`  out  1  completed command was a write.
- `rsp_data`  out  8  read byte for reads, 0 for writes.
- `err_timeout`  out  1  one-cycle pulse when a command is aborted.
- `fifo_count`  out  $clog2(DEPTH)+1  entries held.
- `idle`  out  1  FSM in IDLE and FIFO empty.

## Operation
- FIFO: circular, wrap-around pointers. `req_ready = (fifo_count != DEPTH)`, derived from count only. A push while full is ignored even if a pop occurs the same cycle. Simultaneous push and pop leave the count unchanged.
- FSM states:
  - IDLE: if FIFO non-empty → LAUNCH.
  - LAUNCH, one cycle:
    - `m_start=1`.
    - Pop head into the `m_header`/`m_data` registers.
    - Clear the timeout counter.
    - → WAIT_BUSY.
  - WAIT_BUSY:
    - `m_busy=1` → WAIT_DONE.
    - Else increment the counter. When the counter reaches TIMEOUT-1: pulse `err_timeout`, no `rsp_valid`, → IDLE.
  - WAIT_DONE: `m_busy=0` → RESP.
  - RESP, one cycle:
    - `rsp_valid=1`.
    - `rsp_write=m_header[0]`.
    - `rsp_data = m_header[0] ? 0 : m_rdata` (sampled this cycle).
    - → IDLE.
- `m_header`/`m_data` are registered, loaded only in LAUNCH, and held until the next LAUNCH.
- Only one transaction is outstanding at a time; no pipelining of launches.
- Reset (any state) clears:
  - FIFO and count → 0.
  - State → IDLE.
  - All outputs → 0, except `req_ready=1` and `idle=1`.

## Timing
- Push accepted in cycle C → FSM IDLE sees non-empty in C+1 → `m_start` high in C+2 (if idle). Minimum latency is 2 cycles.
- `m_start` is exactly one cycle wide, and `m_header`/`m_data` are valid in that same cycle.
- `m_busy` falls in cycle D → `rsp_valid` in D+1, using `m_rdata` sampled in D+1.
- Minimum spacing between consecutive `m_start` pulses: LAUNCH + ≥1 WAIT_BUSY + ≥1 WAIT_DONE + RESP + IDLE = 5 cycles.
- Timeout: with `m_busy` held 0, `err_timeout` pulses TIMEOUT cycles after the `m_start` cycle.
- `m_busy` already high in the first WAIT_BUSY cycle is accepted immediately.
- `fifo_count` updates on the edge after push/pop.

## Structure
- `fcp6_pkg` holds:
  - State enum.
  - `HDR_DIR_BIT=0`.
  - `HDR_WIDTH=8`.
  - `DATA_WIDTH=8`.
- One sub-module, `fcp6_cmd_fifo`: DEPTH×16-bit synchronous FIFO with push/pop/count/full/empty. It uses the same `clk`/`rst`.
- The sequencer top contains the FSM, timeout counter, output registers and response logic.

## Test plan
- Write: push header 0x05, data 0x10 into the empty idle block.
  - `m_start` one cycle, 2 cycles after acceptance, with `m_header=0x05`, `m_data=0x10`.
  - Model busy high 20 cycles; `rsp_valid=1`, `rsp_write=1`, `rsp_data=0x00` the cycle after busy falls.
- Read: header 0x04, data 0xA5, master model returns `m_rdata=0x58` → `rsp_valid`, `rsp_write=0`, `rsp_data=0x58`.
- Back-pressure:
  - Push 5 commands back-to-back with busy held high on the first → `req_ready` drops once `fifo_count=4` and the 5th is held.
  - Commands are issued in push order, and exactly 5 `rsp_valid` pulses follow.
- Timeout: push one read, never raise `m_busy` → `err_timeout` 64 cycles after `m_start`, no `rsp_valid`, next queued command launches.
- Reset mid-operation: assert `rst` one cycle during WAIT_DONE with 2 queued → `fifo_count=0`, `idle=1`, no `rsp_valid`, no further `m_start`.
- Full + pop same cycle: with FIFO full and LAUNCH popping, a push attempt is not accepted and the count drops to DEPTH-1.
